// File: rtl/board_pkg.sv
// Shared cell codes, result codes and FSM encoding for the game-board storage slice.
package board_pkg;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] PLAYER1 = 2'b11;
  localparam logic [1:0] PLAYER2 = 2'b10;

  // Win-checker result codes, kept here so both sides of the board agree.
  localparam logic [1:0] NOWIN = 2'b00;
  localparam logic [1:0] TIE   = 2'b01;
  localparam logic [1:0] P2WIN = 2'b10;
  localparam logic [1:0] P1WIN = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_e;

endpackage

// File: rtl/board_mem_array_if.sv
// Move-entry / board-storage bus: write handshake, clear/undo controls and board status.
interface board_mem_array_if #(
  parameter int N      = 3,
  parameter int CELL_W = 2
);
  localparam int CELLS  = N * N;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);

  // Handshake: a write is accepted on a ph1 edge where wr_valid && wr_ready.
  // While wr_ready is low the requester holds wr_valid/wr_addr/wr_state; the
  // outcome of an accepted write or undo is a single-cycle wr_ack or wr_err
  // in the cycle that follows it (never both).
  logic                    wr_valid;
  logic [ADDR_W-1:0]       wr_addr;
  logic [CELL_W-1:0]       wr_state;
  logic                    wr_ready;
  logic                    wr_ack;
  logic                    wr_err;
  logic                    clear;
  logic                    undo;
  logic [CELLS*CELL_W-1:0] board;
  logic [CNT_W-1:0]        move_cnt;
  logic                    full;
  logic                    busy;
  logic                    dbg_state;

  modport master (
    output wr_valid, wr_addr, wr_state, clear, undo,
    input  wr_ready, wr_ack, wr_err, board, move_cnt, full, busy, dbg_state
  );

  modport slave (
    input  wr_valid, wr_addr, wr_state, clear, undo,
    output wr_ready, wr_ack, wr_err, board, move_cnt, full, busy, dbg_state
  );

endinterface

// File: rtl/board_hist_lifo.sv
// Address stack recording legal moves for undo; only built when BOARD_MEM_UNDO_EN is defined.
module board_hist_lifo #(
  parameter int  DEPTH = 9,
  parameter int  W     = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q;

  assign count = cnt_q;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = mem[i];
    end
  end

  // Storage needs no reset: entries above cnt_q are never observed.
  always_ff @(posedge ph1) begin
    if (push && !clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q == CW'(i)) mem[i] <= din;
      end
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (push && cnt_q != CW'(DEPTH)) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/board_mem_array.sv
// N x N game-board storage with checked writes, move counter and sequential clear sweep.
// Define BOARD_MEM_UNDO_EN to add last-move undo backed by board_hist_lifo.
module board_mem_array
  import board_pkg::*;
#(
  parameter int N      = 3,
  parameter int CELL_W = 2
) (
  input logic              ph1,
  input logic              reset,
  board_mem_array_if.slave bus
);

  localparam int CELLS  = N * N;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_CLEAR = CLEAR;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [CELL_W-1:0] cells_q [CELLS];
  logic [CNT_W-1:0]  cnt;
  logic              ack_q;
  logic              err_q;

  logic              idle;
  logic              sweep_last;
  logic              addr_ok;
  logic [CELL_W-1:0] cur_cell;
  logic              legal;
  logic              undo_req;
  logic              pop_ok;
  logic [ADDR_W-1:0] hist_top;

  assign idle       = (state == ST_IDLE);
  assign sweep_last = (state == ST_CLEAR) && (sweep_idx == ADDR_W'(CELLS - 1));

`ifdef BOARD_MEM_UNDO_EN
  logic [CNT_W-1:0] hist_cnt;

  assign undo_req = bus.undo;
  assign pop_ok   = (hist_cnt != '0);

  board_hist_lifo #(
    .DEPTH (CELLS),
    .W     (ADDR_W)
  ) u_hist (
    .ph1   (ph1),
    .reset (reset),
    .push  (idle && !bus.clear && !undo_req && bus.wr_valid && legal),
    .pop   (idle && !bus.clear && undo_req && pop_ok),
    .clr   (sweep_last),
    .din   (bus.wr_addr),
    .top   (hist_top),
    .count (hist_cnt)
  );
`else
  logic unused_undo;

  assign unused_undo = bus.undo;
  assign undo_req    = 1'b0;
  assign pop_ok      = 1'b0;
  assign hist_top    = '0;
`endif

  // Out-of-range addresses simply never match, so they read as not-ok.
  always_comb begin
    addr_ok  = 1'b0;
    cur_cell = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (bus.wr_addr == ADDR_W'(i)) begin
        addr_ok  = 1'b1;
        cur_cell = cells_q[i];
      end
    end
  end

  assign legal = addr_ok && (cur_cell == CELL_W'(EMPTY)) && (bus.wr_state != CELL_W'(EMPTY));

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sweep_idx <= '0;
      cnt       <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state == ST_CLEAR) begin
        for (int i = 0; i < CELLS; i++) begin
          if (sweep_idx == ADDR_W'(i)) cells_q[i] <= '0;
        end
        if (sweep_last) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          sweep_idx <= sweep_idx + ADDR_W'(1);
        end
      end else if (bus.clear) begin
        state     <= ST_CLEAR;
        sweep_idx <= '0;
      end else if (undo_req) begin
        if (pop_ok) begin
          for (int i = 0; i < CELLS; i++) begin
            if (hist_top == ADDR_W'(i)) cells_q[i] <= '0;
          end
          cnt   <= cnt - CNT_W'(1);
          ack_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else if (bus.wr_valid) begin
        if (legal) begin
          for (int i = 0; i < CELLS; i++) begin
            if (bus.wr_addr == ADDR_W'(i)) cells_q[i] <= bus.wr_state;
          end
          cnt   <= cnt + CNT_W'(1);
          ack_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CELLS; g++) begin : g_pack
    assign bus.board[g*CELL_W +: CELL_W] = cells_q[g];
  end

  assign bus.wr_ready  = idle && !bus.clear && !undo_req;
  assign bus.wr_ack    = ack_q;
  assign bus.wr_err    = err_q;
  assign bus.move_cnt  = cnt;
  assign bus.full      = (cnt == CNT_W'(CELLS));
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_board_mem_array.sv
// Self-checking bench for board_mem_array: directed boundary cases plus random traffic
// against a cycle-level behavioural board model (undo section follows BOARD_MEM_UNDO_EN).
module tb_board_mem_array;

`ifdef BOARD_MEM_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif
  localparam int CELLS = 9;

  logic ph1   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  board_mem_array_if #(.N(3), .CELL_W(2)) bus ();

  board_mem_array #(.N(3), .CELL_W(2)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 ph1 = ~ph1;

  // ---------------- behavioural model ----------------
  int m_cells [CELLS];
  int m_cnt;
  bit m_busy;
  int m_sweep;
  bit m_ack;
  bit m_err;
  int hist [$];

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) m_cells[i] = 0;
    m_cnt = 0; m_busy = 0; m_sweep = 0; m_ack = 0; m_err = 0;
    hist.delete();
  endtask

  task automatic model_step();
    int a;
    int s;
    m_ack = 0;
    m_err = 0;
    a = int'(bus.wr_addr);
    s = int'(bus.wr_state);
    if (m_busy) begin
      m_cells[m_sweep] = 0;
      if (m_sweep == CELLS - 1) begin
        m_busy = 0;
        m_cnt  = 0;
        hist.delete();
      end else begin
        m_sweep++;
      end
    end else if (bus.clear) begin
      m_busy  = 1;
      m_sweep = 0;
    end else if (UNDO_EN && bus.undo) begin
      if (hist.size() > 0) begin
        m_cells[hist.pop_back()] = 0;
        m_cnt--;
        m_ack = 1;
      end else begin
        m_err = 1;
      end
    end else if (bus.wr_valid) begin
      if (a < CELLS && s != 0 && m_cells[a] == 0) begin
        m_cells[a] = s;
        m_cnt++;
        hist.push_back(a);
        m_ack = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge ph1 or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < CELLS; i++) b[i*2 +: 2] = 2'(m_cells[i]);
    return b;
  endfunction

  initial begin
    forever begin
      @(negedge ph1);
      if (chk_en && !reset) begin
        check("board",    32'(bus.board),    32'(model_board()));
        check("move_cnt", 32'(bus.move_cnt), 32'(m_cnt));
        check("full",     32'(bus.full),     32'(m_cnt == CELLS));
        check("busy",     32'(bus.busy),     32'(m_busy));
        check("wr_ack",   32'(bus.wr_ack),   32'(m_ack));
        check("wr_err",   32'(bus.wr_err),   32'(m_err));
        check("wr_ready", 32'(bus.wr_ready),
              32'(!m_busy && !bus.clear && !(UNDO_EN && bus.undo)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_state = '0;
    bus.clear    = 1'b0;
    bus.undo     = 1'b0;
  endtask

  task automatic write_cell(input int a, input int s);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'(a);
    bus.wr_state = 2'(s);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    if (bus.busy) check("sweep_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic clear_board();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  logic [17:0] b;
  int bc;

  initial begin
    drive_idle();
    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    @(negedge ph1);
    check("rst_board", 32'(bus.board),    32'd0);
    check("rst_cnt",   32'(bus.move_cnt), 32'd0);
    check("rst_full",  32'(bus.full),     32'd0);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_ack",   32'(bus.wr_ack),   32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);

    write_cell(4, 3);
    @(negedge ph1);
    b = bus.board;
    check("w4_ack",  32'(bus.wr_ack),   32'd1);
    check("w4_cell", 32'(b[9:8]),       32'd3);
    check("w4_cnt",  32'(bus.move_cnt), 32'd1);

    write_cell(4, 2);
    @(negedge ph1);
    b = bus.board;
    check("occ_err",  32'(bus.wr_err),   32'd1);
    check("occ_ack",  32'(bus.wr_ack),   32'd0);
    check("occ_cell", 32'(b[9:8]),       32'd3);
    check("occ_cnt",  32'(bus.move_cnt), 32'd1);

    write_cell(9, 3);
    @(negedge ph1);
    check("oor_err", 32'(bus.wr_err), 32'd1);

    write_cell(0, 0);
    @(negedge ph1);
    check("empty_err", 32'(bus.wr_err),   32'd1);
    check("empty_cnt", 32'(bus.move_cnt), 32'd1);

    clear_board();
    for (int a = 0; a < CELLS; a++) write_cell(a, (a % 2 == 1) ? 2 : 3);
    @(negedge ph1);
    check("fill_full", 32'(bus.full),     32'd1);
    check("fill_cnt",  32'(bus.move_cnt), 32'd9);
    write_cell(0, 2);
    @(negedge ph1);
    check("full_err", 32'(bus.wr_err), 32'd1);

    // clear with a held write request: sweep first, then the write lands
    clear_board();
    for (int a = 0; a < 5; a++) write_cell(a, 2);
    bus.clear    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd6;
    bus.wr_state = 2'd3;
    @(negedge ph1);
    check("clr_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    bus.clear = 1'b0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ph1);
      if (!bus.busy) break;
      bc++;
      tick();
    end
    check("sweep_len",   32'(bc),           32'd9);
    check("sweep_cnt",   32'(bus.move_cnt), 32'd0);
    check("sweep_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;

    // async reset during the 4th sweep cycle
    write_cell(1, 3);
    write_cell(2, 2);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_board", 32'(bus.board),    32'd0);
    check("mid_rst_cnt",   32'(bus.move_cnt), 32'd0);
    @(negedge ph1);
    reset = 1'b0;
    write_cell(8, 2);
    @(negedge ph1);
    check("post_rst_ack", 32'(bus.wr_ack),   32'd1);
    check("post_rst_cnt", 32'(bus.move_cnt), 32'd1);

`ifdef BOARD_MEM_UNDO_EN
    clear_board();
    write_cell(0, 3);
    write_cell(8, 2);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    @(negedge ph1);
    b = bus.board;
    check("undo1_cell", 32'(b[17:16]),     32'd0);
    check("undo1_keep", 32'(b[1:0]),       32'd3);
    check("undo1_cnt",  32'(bus.move_cnt), 32'd1);
    check("undo1_ack",  32'(bus.wr_ack),   32'd1);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    @(negedge ph1);
    check("undo2_ack", 32'(bus.wr_ack),   32'd1);
    check("undo2_cnt", 32'(bus.move_cnt), 32'd0);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    @(negedge ph1);
    check("undo3_err", 32'(bus.wr_err), 32'd1);
`else
    bus.undo = 1'b1;
    write_cell(5, 3);
    bus.undo = 1'b0;
    @(negedge ph1);
    check("noundo_ack", 32'(bus.wr_ack),   32'd1);
    check("noundo_cnt", 32'(bus.move_cnt), 32'd2);
`endif

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = 4'($urandom_range(0, 15));
      bus.wr_state = 2'($urandom_range(0, 3));
      bus.clear    = ($urandom_range(0, 39) == 0);
      bus.undo     = ($urandom_range(0, 6) == 0);
      tick();
    end

    drive_idle();
    tick();
    @(negedge ph1);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_mem_array.md
Name: board_mem_array

Overview:
- Parametrised N×N game-board storage: successor to the fixed 3×3, 2-bit-per-cell board memory.
- Adds a write handshake, rejection of illegal moves, a move counter and full flag, and a sequential clear sweep.
- Optionally adds a last-move undo history.
- Sits between the move-entry controller and the win-detection logic; `board` feeds the win checker directly.

Parameters:
- N, 3: board side; cell count CELLS = N*N (localparam).
- CELL_W, 2: bits per cell state; 0 always means empty.
- ADDR_W, $clog2(N*N): cell address width (localparam).
- CNT_W, $clog2(N*N+1): move-counter width (localparam).

Ports:
- ph1  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- wr_valid  in  1  move request.
- wr_addr  in  ADDR_W  target cell, row-major, 0 = upper-left.
- wr_state  in  CELL_W  value to write (player code).
- wr_ready  out  1  request accepted this cycle if wr_valid is high.
- wr_ack  out  1  one-cycle pulse: previous request written.
- wr_err  out  1  one-cycle pulse: previous request/undo rejected.
- clear  in  1  start board clear sweep.
- undo  in  1  remove last move (UNDO_EN only).
- board  out  N*N*CELL_W  cell i at [i*CELL_W +: CELL_W].
- move_cnt  out  CNT_W  number of occupied cells.
- full  out  1  move_cnt == CELLS.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async): board all 0, move_cnt 0, full 0, wr_ack/wr_err 0, busy 0, FSM = IDLE, history empty.
- FSM has two states, IDLE and CLEAR.
- wr_ready (combinational) = (state==IDLE) && !clear && !undo.
- Accepted write = wr_valid && wr_ready at a ph1 edge.
- Legal write: addr < CELLS, target cell == 0, wr_state != 0.
  - Cell is written at that edge and visible on `board` the next cycle.
  - move_cnt increments; wr_ack is high for the following cycle.
- Illegal accepted write: board and move_cnt unchanged; wr_err is high for the following cycle.
- wr_ack and wr_err are never high together.
- wr_valid while wr_ready=0: ignored, no ack/err; the requester must hold the request.
- clear in IDLE: moves to CLEAR on the next edge.
  - busy=1 during CLEAR; one cell is zeroed per cycle, index 0..CELLS-1.
  - Cells not yet swept keep their values.
  - After cell CELLS-1 is zeroed: move_cnt=0, history emptied, return to IDLE.
  - Total sweep length is CELLS cycles.
- clear while in CLEAR: ignored; the sweep does not restart.
- Priority in IDLE: clear > undo > write.
- full is asserted while move_cnt == CELLS. Every write then targets an occupied cell, so it produces wr_err.
- Async reset mid-sweep: immediately returns to the reset state; partial sweep is discarded.

Optional Feature:
- Macro: BOARD_MEM_UNDO_EN.
- Defined:
  - A CELLS-deep address LIFO records each legal write.
  - undo in IDLE with move_cnt>0 pops the top address, zeroes that cell, decrements move_cnt, and pulses wr_ack next cycle.
  - undo with move_cnt==0 pulses wr_err, no state change.
  - The LIFO never overflows, because the CELLS legal writes preceding full fill it exactly.
- Undefined: undo port is present but ignored, with no history storage. wr_ready ignores undo.

Decomposition:
- Package board_pkg holds:
  - Cell codes EMPTY=2'b00, PLAYER1=2'b11, PLAYER2=2'b10.
  - Result codes NOWIN=00, TIE=01, P2WIN=10, P1WIN=11.
  - FSM enum {IDLE, CLEAR}.
- One sub-module, board_hist_lifo: parametrised address stack with push, pop, clear, top and count. Instantiated only under BOARD_MEM_UNDO_EN.

Test Plan:
- Reset; write addr 4 with state 2'b11 → next cycle wr_ack=1, board[9:8]=11, move_cnt=1.
- Write addr 4 again with 2'b10 → wr_err=1, board[9:8] stays 11, move_cnt=1. Write addr 9 → wr_err=1.
- Fill all 9 cells legally → full=1 after 9th ack. A 10th write to addr 0 → wr_err=1.
- Fill 5 cells, pulse clear with wr_valid high → no ack/err, busy=1 for 9 cycles, cell k zero after cycle k, then move_cnt=0, wr_ready=1.
- Assert reset during the 4th sweep cycle → board all 0, busy=0 immediately; release and write addr 8 → ack.
- (UNDO_EN) Write 0 then 8, undo → cell 8 = 0, move_cnt=1. Undo twice more → ack then wr_err.
